// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
//
// Shares the single register-file write port between the pipeline WB stage
// and the multi-cycle mul/div unit (MDU). MDU results are buffered in a
// 2-entry in-order FIFO. WB has priority on the port. A WB write to rd=R
// squashes every buffered MDU result for R, including one pushed in the same
// cycle. Squashed entries and entries targeting x0 still pop in order, but
// they never write the register file.
//
// Optional feature macro: RF_ARB_STARVE_GUARD_EN
//   defined   : NORMAL/FORCE state machine. After STARVE_MAX consecutive
//               cycles in which WB blocks a live FIFO head, the arbiter spends
//               one cycle in FORCE. In that cycle it stalls WB and writes the
//               head.
//   undefined : WB always wins, wb_stall_o is tied low, no counter.
//
// Ports
//   clk_i          in   1       clock, all state on posedge
//   rst_n          in   1       synchronous active-low reset
//   wb_valid_i     in   1       WB write request (RegWrite)
//   wb_rd_addr_i   in   ADDR_W  WB destination index
//   wb_rd_data_i   in   DATA_W  WB write data
//   wb_stall_o     out  1       WB must hold its request this cycle
//   mdu_valid_i    in   1       MDU result valid
//   mdu_rd_addr_i  in   ADDR_W  MDU destination index
//   mdu_rd_data_i  in   DATA_W  MDU result
//   mdu_ready_o    out  1       FIFO can accept (push = valid & ready)
//   mdu_pending_o  out  2       FIFO occupancy 0..2
//   RegWrite_o     out  1       register-file write enable
//   rd_addr_o      out  ADDR_W  register-file write index
//   rd_data_o      out  DATA_W  register-file write data
// -----------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wb_valid_i,
  input  logic [ADDR_W-1:0] wb_rd_addr_i,
  input  logic [DATA_W-1:0] wb_rd_data_i,
  output logic              wb_stall_o,
  input  logic              mdu_valid_i,
  input  logic [ADDR_W-1:0] mdu_rd_addr_i,
  input  logic [DATA_W-1:0] mdu_rd_data_i,
  output logic              mdu_ready_o,
  output logic [1:0]        mdu_pending_o,
  output logic              RegWrite_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2;

  // FIFO storage; index 0 is always the head (shift-on-pop).
  logic [ADDR_W-1:0] fifo_addr_reg  [DEPTH];
  logic [DATA_W-1:0] fifo_data_reg  [DEPTH];
  logic [DEPTH-1:0]  fifo_sq_reg;
  logic [1:0]        count_reg;

  logic [ADDR_W-1:0] fifo_addr_next [DEPTH];
  logic [DATA_W-1:0] fifo_data_next [DEPTH];
  logic [DEPTH-1:0]  fifo_sq_next;
  logic [1:0]        count_next;

  logic              head_valid;
  logic              head_dead;
  logic              head_live;
  logic              wb_req;
  logic              wb_grant;
  logic              force_active;
  logic              pop;
  logic              push;
  logic              push_sq;
  logic [DEPTH-1:0]  sq_after;
  logic [1:0]        count_after_pop;
  logic              wr_idx;

  // A dead head (squashed or x0) never needs the port, so it retires at once.
  assign head_valid = (count_reg != 2'd0);
  assign head_dead  = fifo_sq_reg[0] | (fifo_addr_reg[0] == '0);
  assign head_live  = head_valid & ~head_dead;

  // x0 WB requests are consumed but never take the port.
  assign wb_req   = wb_valid_i & (wb_rd_addr_i != '0);
  assign wb_grant = wb_req & ~force_active;

  assign pop = head_valid & (force_active | head_dead | ~wb_req);

  assign mdu_ready_o   = rst_n & (count_reg < 2'd2);
  assign mdu_pending_o = rst_n ? count_reg : 2'd0;
  assign wb_stall_o    = rst_n & force_active;

  assign push    = mdu_valid_i & mdu_ready_o;
  assign push_sq = wb_grant & (mdu_rd_addr_i == wb_rd_addr_i);

  // A granted WB write makes any buffered result for the same register stale.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_squash
      assign sq_after[gi] = fifo_sq_reg[gi] |
                            (wb_grant & (fifo_addr_reg[gi] == wb_rd_addr_i));
    end
  endgenerate

  // A push lands in the first free slot after any pop has shifted the FIFO.
  assign count_after_pop = count_reg - {1'b0, pop};
  assign wr_idx          = count_after_pop[0];
  assign count_next      = count_after_pop + {1'b0, push};

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_addr_next[i] = fifo_addr_reg[i];
      fifo_data_next[i] = fifo_data_reg[i];
    end
    fifo_sq_next = sq_after;
    if (pop) begin
      fifo_addr_next[0] = fifo_addr_reg[1];
      fifo_data_next[0] = fifo_data_reg[1];
      fifo_sq_next[0]   = sq_after[1];
    end
    if (push) begin
      fifo_addr_next[wr_idx] = mdu_rd_addr_i;
      fifo_data_next[wr_idx] = mdu_rd_data_i;
      fifo_sq_next[wr_idx]   = push_sq;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      count_reg   <= 2'd0;
      fifo_sq_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_reg[i] <= '0;
        fifo_data_reg[i] <= '0;
      end
    end else begin
      count_reg   <= count_next;
      fifo_sq_reg <= fifo_sq_next;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_reg[i] <= fifo_addr_next[i];
        fifo_data_reg[i] <= fifo_data_next[i];
      end
    end
  end

  // Write port. This is combinational, and the register file commits it on the next edge.
  always_comb begin
    RegWrite_o = 1'b0;
    rd_addr_o  = '0;
    rd_data_o  = '0;
    if (rst_n) begin
      if (wb_grant) begin
        RegWrite_o = 1'b1;
        rd_addr_o  = wb_rd_addr_i;
        rd_data_o  = wb_rd_data_i;
      end else if (pop && head_live) begin
        RegWrite_o = 1'b1;
        rd_addr_o  = fifo_addr_reg[0];
        rd_data_o  = fifo_data_reg[0];
      end
    end
  end

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic             head_blocked;

  assign force_active = (state_reg == ST_FORCE);
  // If the head is not blocked, it is either popping or the FIFO is empty.
  assign head_blocked = head_live & wb_req & ~force_active;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_reg      <= ST_NORMAL;
      starve_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_NORMAL: begin
          if (head_blocked) begin
            if (starve_cnt_reg == CNT_W'(STARVE_MAX - 1)) begin
              state_reg      <= ST_FORCE;
              starve_cnt_reg <= '0;
            end else begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
          end else begin
            starve_cnt_reg <= '0;
          end
        end
        default: begin
          // One forced head write, then WB gets the port back.
          state_reg      <= ST_NORMAL;
          starve_cnt_reg <= '0;
        end
      endcase
    end
  end
`else
  // STARVE_MAX only matters in the guard build.
  localparam int unused_starve_max = STARVE_MAX;
  assign force_active = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Directed scenarios for rf_write_arbiter. Each scenario pushes the expected
// register-file writes into a queue as it drives stimulus. Every cycle, any
// observed write is popped from the queue and compared against it. The guard
// scenario follows whichever build RF_ARB_STARVE_GUARD_EN selects.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        wb_valid_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_rd_data_i;
  logic        wb_stall_o;
  logic        mdu_valid_i;
  logic [4:0]  mdu_rd_addr_i;
  logic [31:0] mdu_rd_data_i;
  logic        mdu_ready_o;
  logic [1:0]  mdu_pending_o;
  logic        RegWrite_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  // Snapshot of the outputs taken at the negedge of the last cycle.
  logic        rw_s;
  logic [4:0]  addr_s;
  logic [31:0] data_s;
  logic        stall_s;
  logic        ready_s;
  logic [1:0]  pend_s;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  rf_write_arbiter #(
    .DATA_W     (32),
    .ADDR_W     (5),
    .STARVE_MAX (4)
  ) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .wb_valid_i    (wb_valid_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_rd_data_i  (wb_rd_data_i),
    .wb_stall_o    (wb_stall_o),
    .mdu_valid_i   (mdu_valid_i),
    .mdu_rd_addr_i (mdu_rd_addr_i),
    .mdu_rd_data_i (mdu_rd_data_i),
    .mdu_ready_o   (mdu_ready_o),
    .mdu_pending_o (mdu_pending_o),
    .RegWrite_o    (RegWrite_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_valid_i    = wv;
    wb_rd_addr_i  = wa;
    wb_rd_data_i  = wd;
    mdu_valid_i   = mv;
    mdu_rd_addr_i = ma;
    mdu_rd_data_i = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One clock cycle: sample at negedge, score any write, then advance past posedge.
  task automatic cycle();
    wr_t e;
    @(negedge clk_i);
    rw_s    = RegWrite_o;
    addr_s  = rd_addr_o;
    data_s  = rd_data_o;
    stall_s = wb_stall_o;
    ready_s = mdu_ready_o;
    pend_s  = mdu_pending_o;
    if (rw_s) begin
      $display("wr   rd=%0d data=0x%0h stall=%0d pending=%0d", addr_s, data_s, stall_s, pend_s);
      if (exp_q.size() == 0) begin
        check_val("spurious_write", 64'(rw_s), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("wr_addr", 64'(addr_s), 64'(e.addr));
        check_val("wr_data", 64'(data_s), 64'(e.data));
      end
    end else begin
      check_val("idle_port", 64'({addr_s, data_s}), 64'd0);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain_check(input string tag);
    check_val(tag, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk_i);
    #1;

    // Reset with MDU and WB both requesting: nothing gets through.
    for (int i = 0; i < 2; i++) begin
      rst_n = 1'b0;
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
      cycle();
      check_val("rst_regwrite", 64'(rw_s), 64'd0);
      check_val("rst_ready", 64'(ready_s), 64'd0);
      check_val("rst_pending", 64'(pend_s), 64'd0);
      check_val("rst_stall", 64'(stall_s), 64'd0);
    end
    rst_n = 1'b1;
    idle();
    cycle();
    check_val("post_rst_ready", 64'(ready_s), 64'd1);
    check_val("post_rst_pending", 64'(pend_s), 64'd0);

    // MDU alone: one-cycle latency, no bypass.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    cycle();
    check_val("mdu_no_bypass", 64'(rw_s), 64'd0);
    check_val("mdu_ready", 64'(ready_s), 64'd1);
    expect_wr(5'd5, 32'h1234);
    idle();
    cycle();
    check_val("mdu_lat1", 64'(rw_s), 64'd1);
    check_val("mdu_pend1", 64'(pend_s), 64'd1);
    cycle();
    check_val("mdu_pend0", 64'(pend_s), 64'd0);
    drain_check("drain_mdu");

    // Full FIFO while WB is busy; the third result is refused.
    expect_wr(5'd10, 32'h100);
    drive(1'b1, 5'd10, 32'h100, 1'b1, 5'd1, 32'h11);
    cycle();
    expect_wr(5'd11, 32'h101);
    drive(1'b1, 5'd11, 32'h101, 1'b1, 5'd2, 32'h22);
    cycle();
    check_val("full_pend1", 64'(pend_s), 64'd1);
    expect_wr(5'd12, 32'h102);
    drive(1'b1, 5'd12, 32'h102, 1'b1, 5'd3, 32'h33);
    cycle();
    check_val("full_ready", 64'(ready_s), 64'd0);
    check_val("full_pend2", 64'(pend_s), 64'd2);
    expect_wr(5'd1, 32'h11);
    idle();
    cycle();
    check_val("full_drain_pend2", 64'(pend_s), 64'd2);
    expect_wr(5'd2, 32'h22);
    cycle();
    check_val("full_drain_pend1", 64'(pend_s), 64'd1);
    cycle();
    check_val("full_drain_pend0", 64'(pend_s), 64'd0);
    drain_check("drain_full");

    // Squash of a buffered entry.
    expect_wr(5'd4, 32'h44);
    drive(1'b1, 5'd4, 32'h44, 1'b1, 5'd7, 32'hAA);
    cycle();
    expect_wr(5'd7, 32'hBB);
    drive(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    cycle();
    idle();
    cycle();
    check_val("squash_silent", 64'(rw_s), 64'd0);
    check_val("squash_pend1", 64'(pend_s), 64'd1);
    cycle();
    check_val("squash_pend0", 64'(pend_s), 64'd0);
    // Squash of a result pushed in the same cycle as the WB write.
    expect_wr(5'd8, 32'hC1);
    drive(1'b1, 5'd8, 32'hC1, 1'b1, 5'd8, 32'hC2);
    cycle();
    idle();
    cycle();
    check_val("squash_push_silent", 64'(rw_s), 64'd0);
    check_val("squash_push_pend1", 64'(pend_s), 64'd1);
    cycle();
    check_val("squash_push_pend0", 64'(pend_s), 64'd0);
    drain_check("drain_squash");

    // x0 cases.
    expect_wr(5'd6, 32'h66);
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd3, 32'h11);
    cycle();
    expect_wr(5'd3, 32'h11);
    drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    cycle();
    check_val("x0_head_wins", 64'(rw_s), 64'd1);
    check_val("x0_no_stall", 64'(stall_s), 64'd0);
    idle();
    cycle();
    check_val("x0_pend0", 64'(pend_s), 64'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h55);
    cycle();
    idle();
    cycle();
    check_val("x0_mdu_silent", 64'(rw_s), 64'd0);
    check_val("x0_mdu_pend1", 64'(pend_s), 64'd1);
    cycle();
    check_val("x0_mdu_pend0", 64'(pend_s), 64'd0);
    drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    cycle();
    check_val("x0_wb_silent", 64'(rw_s), 64'd0);
    drain_check("drain_x0");

    // Reset mid-operation discards buffered results.
    expect_wr(5'd13, 32'h130);
    drive(1'b1, 5'd13, 32'h130, 1'b1, 5'd14, 32'hE0);
    cycle();
    expect_wr(5'd15, 32'h150);
    drive(1'b1, 5'd15, 32'h150, 1'b1, 5'd16, 32'hE1);
    cycle();
    check_val("midrst_pend1", 64'(pend_s), 64'd1);
    rst_n = 1'b0;
    idle();
    cycle();
    check_val("midrst_pend_forced", 64'(pend_s), 64'd0);
    rst_n = 1'b1;
    cycle();
    check_val("midrst_pend0", 64'(pend_s), 64'd0);
    cycle();
    check_val("midrst_silent", 64'(rw_s), 64'd0);
    drain_check("drain_midrst");

    // Starvation: WB requests every cycle while r9 waits at the head.
    expect_wr(5'd20, 32'h200);
    drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd9, 32'h99);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      expect_wr(5'(20 + k), 32'(32'h200 + k));
      drive(1'b1, 5'(20 + k), 32'(32'h200 + k), 1'b0, 5'd0, 32'd0);
      cycle();
      check_val("starve_no_stall", 64'(stall_s), 64'd0);
    end
`ifdef RF_ARB_STARVE_GUARD_EN
    expect_wr(5'd9, 32'h99);
    drive(1'b1, 5'd25, 32'h205, 1'b0, 5'd0, 32'd0);
    cycle();
    check_val("force_stall", 64'(stall_s), 64'd1);
    check_val("force_write", 64'(rw_s), 64'd1);
    expect_wr(5'd25, 32'h205);
    cycle();
    check_val("force_release", 64'(stall_s), 64'd0);
    check_val("force_pend0", 64'(pend_s), 64'd0);
`else
    for (int k = 5; k <= 7; k++) begin
      expect_wr(5'(20 + k), 32'(32'h200 + k));
      drive(1'b1, 5'(20 + k), 32'(32'h200 + k), 1'b0, 5'd0, 32'd0);
      cycle();
      check_val("noguard_stall", 64'(stall_s), 64'd0);
      check_val("noguard_pend1", 64'(pend_s), 64'd1);
    end
    expect_wr(5'd9, 32'h99);
    idle();
    cycle();
    check_val("noguard_r9", 64'(rw_s), 64'd1);
`endif
    idle();
    cycle();
    check_val("starve_end_pend0", 64'(pend_s), 64'd0);
    drain_check("drain_starve");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
